masked_sram_1r1w: RTL and testbench

Parametrised single-clock 1R1W SRAM with configurable width, depth and write-mask granularity, replacing the fixed 1024x32 byte-masked array macros. It adds a post-reset hardware clear sequence, write-first bypass on same-address read/write collisions, an optional output pipeline stage, and a read-valid strobe. It sits behind the cache data/tag arrays and shared-memory banks.

---
 rtl/sram_pkg.sv | 28 ++
 rtl/sram_clear_ctl.sv | 78 +++++++
 rtl/masked_sram_1r1w.sv | 137 +++++++++++++
 tb/tb_masked_sram_1r1w.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and lane-merge helper for the masked 1R1W SRAM.
// Controller states plus the merge used by the write bypass path.
package sram_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } sram_state_e;

  localparam int MAX_W = 256;

  typedef logic [MAX_W-1:0] wide_t;

  // Per-bit select: lane (i / gran) of mask picks new_w, else old_w.
  function automatic wide_t merge(
    input wide_t old_w,
    input wide_t new_w,
    input wide_t mask,
    input int    gran
  );
    wide_t res;
    for (int i = 0; i < MAX_W; i++) begin
      res[i] = mask[i / gran] ? new_w[i] : old_w[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_clear_ctl.sv
// Post-reset clear sequencer and write-port mux for the SRAM array.
// While clearing, the array port is owned by the sweep pointer.
module sram_clear_ctl
  import sram_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int GRAN       = 8,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int INIT_CLEAR = 1,
  localparam int LANES     = DATA_W / GRAN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [LANES-1:0]  w_mask,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [LANES-1:0]  mem_mask,
  output logic              init_busy
);

  localparam sram_state_e RST_STATE =
    (INIT_CLEAR != 0) ? CLEAR : READY;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_L =
    (ADDR_W + 1)'(DEPTH);

  sram_state_e       state, state_d;
  logic [ADDR_W-1:0] ptr, ptr_d;
  logic              w_in_range;

  assign w_in_range = {1'b0, w_addr} < DEPTH_L;
  assign init_busy  = (state == CLEAR);

  // State and sweep pointer register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RST_STATE;
      ptr   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
    end
  end

  // Next state and array write-port selection.
  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    mem_we   = 1'b0;
    mem_addr = w_addr;
    mem_data = w_data;
    mem_mask = w_mask;
    unique case (state)
      CLEAR: begin
        mem_we   = ~reset;
        mem_addr = ptr;
        mem_data = '0;
        mem_mask = '1;
        ptr_d    = ptr + 1'b1;
        if (ptr == LAST) begin
          state_d = READY;
          ptr_d   = '0;
        end
      end
      READY: begin
        mem_we = ~reset & w_en
               & w_in_range & (|w_mask);
      end
    endcase
  end

endmodule

// File: rtl/masked_sram_1r1w.sv
// Parametrised 1R1W SRAM with lane masks, clear sweep,
// write-first collision bypass and optional output register.
module masked_sram_1r1w
  import sram_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int GRAN       = 8,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int OUT_REG    = 0,
  parameter int INIT_CLEAR = 1,
  localparam int LANES     = DATA_W / GRAN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [LANES-1:0]  w_mask,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              init_busy
);

  if (DATA_W % GRAN != 0) begin : g_bad_gran
    $error("DATA_W must be a multiple of GRAN");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("DEPTH must be at least 2");
  end
  if (DATA_W > MAX_W) begin : g_bad_width
    $error("DATA_W exceeds sram_pkg::MAX_W");
  end

  localparam logic [ADDR_W:0] DEPTH_L =
    (ADDR_W + 1)'(DEPTH);

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [LANES-1:0]  mem_mask;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_accept;
  logic              r_in_range;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] q1;
  logic              v1;

  sram_clear_ctl #(
    .DATA_W    (DATA_W),
    .GRAN      (GRAN),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .INIT_CLEAR(INIT_CLEAR)
  ) u_ctl (
    .clock    (clock),
    .reset    (reset),
    .w_en     (w_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .w_mask   (w_mask),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_mask (mem_mask),
    .init_busy(init_busy)
  );

  assign r_in_range = {1'b0, r_addr} < DEPTH_L;
  assign rd_accept  = r_en & ~init_busy & ~reset;

  // Array write with one enable per mask lane.
  always_ff @(posedge clock) begin
    for (int l = 0; l < LANES; l++) begin
      if (mem_we && mem_mask[l]) begin
        mem[mem_addr][l*GRAN +: GRAN] <=
          mem_data[l*GRAN +: GRAN];
      end
    end
  end

  // Read word: zero when out of range, write-first on collision.
  always_comb begin
    rd_word = '0;
    if (r_in_range) begin
      rd_word = mem[r_addr];
    end
    if (mem_we && !init_busy && mem_addr == r_addr) begin
      rd_word = DATA_W'(merge(wide_t'(rd_word),
                              wide_t'(mem_data),
                              wide_t'(mem_mask),
                              GRAN));
    end
  end

  // First read stage: data holds until the next accepted read.
  always_ff @(posedge clock) begin
    if (reset) begin
      q1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= rd_accept;
      if (rd_accept) begin
        q1 <= rd_word;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] q2;
    logic              v2;

    // Optional output stage adding one cycle of latency.
    always_ff @(posedge clock) begin
      if (reset) begin
        q2 <= '0;
        v2 <= 1'b0;
      end else begin
        v2 <= v1;
        if (v1) begin
          q2 <= q1;
        end
      end
    end

    assign r_data  = q2;
    assign r_valid = v2;
  end else begin : g_no_out_reg
    assign r_data  = q1;
    assign r_valid = v1;
  end

endmodule

// File: tb/tb_masked_sram_1r1w.sv
// Self-checking bench: DUT a is 16x32 latency 1,
// DUT b is 12x32 with output register (latency 2).
module tb_masked_sram_1r1w;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic        re;
    logic [3:0]  ra;
    logic [31:0] ex;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        w_en      [2];
  logic [3:0]  w_addr    [2];
  logic [31:0] w_data    [2];
  logic [3:0]  w_mask    [2];
  logic        r_en      [2];
  logic [3:0]  r_addr    [2];
  logic [31:0] r_data    [2];
  logic        r_valid   [2];
  logic        init_busy [2];

  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  exp_t q0[$];
  exp_t q1[$];
  vec_t tbl[16];

  masked_sram_1r1w #(
    .DATA_W(32), .GRAN(8), .DEPTH(16),
    .OUT_REG(0), .INIT_CLEAR(1)
  ) dut_a (
    .clock    (clock),
    .reset    (reset),
    .w_en     (w_en[0]),
    .w_addr   (w_addr[0]),
    .w_data   (w_data[0]),
    .w_mask   (w_mask[0]),
    .r_en     (r_en[0]),
    .r_addr   (r_addr[0]),
    .r_data   (r_data[0]),
    .r_valid  (r_valid[0]),
    .init_busy(init_busy[0])
  );

  masked_sram_1r1w #(
    .DATA_W(32), .GRAN(8), .DEPTH(12),
    .OUT_REG(1), .INIT_CLEAR(1)
  ) dut_b (
    .clock    (clock),
    .reset    (reset),
    .w_en     (w_en[1]),
    .w_addr   (w_addr[1]),
    .w_data   (w_data[1]),
    .w_mask   (w_mask[1]),
    .r_en     (r_en[1]),
    .r_addr   (r_addr[1]),
    .r_data   (r_data[1]),
    .r_valid  (r_valid[1]),
    .init_busy(init_busy[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, want %h",
                  name, act, req);
  endtask

  task automatic push(input int d,
                      input logic [31:0] ex);
    exp_t e;
    e.data = ex;
    e.due  = cyc + ((d == 0) ? 1 : 2);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic op(input int d,
                    input logic we,
                    input logic [3:0] wa,
                    input logic [31:0] wd,
                    input logic [3:0] wm,
                    input logic re,
                    input logic [3:0] ra,
                    input logic [31:0] ex);
    w_en[d]   = we;
    w_addr[d] = wa;
    w_data[d] = wd;
    w_mask[d] = wm;
    r_en[d]   = re;
    r_addr[d] = ra;
    if (re) push(d, ex);
    step();
    w_en[d] = 1'b0;
    r_en[d] = 1'b0;
  endtask

  task automatic sweep(output int c0,
                       output int c1,
                       input logic poke);
    c0 = 0;
    c1 = 0;
    for (int g = 0; g < 100 &&
         (init_busy[0] || init_busy[1]); g++) begin
      if (init_busy[0]) c0++;
      if (init_busy[1]) c1++;
      for (int d = 0; d < 2; d++) begin
        w_en[d]   = poke & init_busy[d];
        w_addr[d] = 4'd0;
        w_data[d] = 32'hFFFF_FFFF;
        w_mask[d] = 4'hF;
        r_en[d]   = poke & init_busy[d];
        r_addr[d] = 4'd0;
      end
      step();
      chk("clr_valid_a", 32'(r_valid[0]), 0);
      chk("clr_valid_b", 32'(r_valid[1]), 0);
    end
    for (int d = 0; d < 2; d++) begin
      w_en[d] = 1'b0;
      r_en[d] = 1'b0;
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (r_valid[0] === 1'b1) begin
      if (q0.size() == 0) begin
        chk("a_spurious_valid", 32'(r_valid[0]), 0);
      end else begin
        e = q0.pop_front();
        chk("a_rdata", r_data[0], e.data);
        chk("a_latency", cyc, e.due);
      end
    end else if (q0.size() > 0 && q0[0].due <= cyc) begin
      chk("a_missing_valid", 32'(r_valid[0]), 1);
      void'(q0.pop_front());
    end
    if (r_valid[1] === 1'b1) begin
      if (q1.size() == 0) begin
        chk("b_spurious_valid", 32'(r_valid[1]), 0);
      end else begin
        e = q1.pop_front();
        chk("b_rdata", r_data[1], e.data);
        chk("b_latency", cyc, e.due);
      end
    end else if (q1.size() > 0 && q1[0].due <= cyc) begin
      chk("b_missing_valid", 32'(r_valid[1]), 1);
      void'(q1.pop_front());
    end
  end

  initial begin
    int c0, c1;

    tbl[0]  = '{1'b1, 4'd5,  32'hAABB_CCDD, 4'hF, 1'b0, 4'd0,  32'h0};
    tbl[1]  = '{1'b1, 4'd5,  32'h1122_3344, 4'h5, 1'b0, 4'd0,  32'h0};
    tbl[2]  = '{1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 4'd5,  32'hAA22_CC44};
    tbl[3]  = '{1'b1, 4'd7,  32'h0,         4'hF, 1'b0, 4'd0,  32'h0};
    tbl[4]  = '{1'b1, 4'd7,  32'hFFFF_FFFF, 4'h3, 1'b1, 4'd7,  32'h0000_FFFF};
    tbl[5]  = '{1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 4'd7,  32'h0000_FFFF};
    tbl[6]  = '{1'b1, 4'd9,  32'hDEAD_BEEF, 4'h0, 1'b0, 4'd0,  32'h0};
    tbl[7]  = '{1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 4'd9,  32'h0};
    tbl[8]  = '{1'b1, 4'd10, 32'h0102_0304, 4'hF, 1'b0, 4'd0,  32'h0};
    tbl[9]  = '{1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 4'd10, 32'h0102_0304};
    tbl[10] = '{1'b1, 4'd11, 32'hFFFF_FFFF, 4'hA, 1'b0, 4'd0,  32'h0};
    tbl[11] = '{1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 4'd11, 32'hFF00_FF00};
    tbl[12] = '{1'b1, 4'd6,  32'hCAFE_BABE, 4'hF, 1'b1, 4'd5,  32'hAA22_CC44};
    tbl[13] = '{1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 4'd6,  32'hCAFE_BABE};
    tbl[14] = '{1'b1, 4'd14, 32'h89AB_CDEF, 4'h2, 1'b1, 4'd14, 32'h0000_CD00};
    tbl[15] = '{1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 4'd15, 32'h0};

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      w_en[d]   = 1'b0;
      r_en[d]   = 1'b0;
      w_addr[d] = 4'd0;
      r_addr[d] = 4'd0;
      w_data[d] = 32'h0;
      w_mask[d] = 4'h0;
    end

    step();
    chk("rst_busy_a", 32'(init_busy[0]), 1);
    chk("rst_busy_b", 32'(init_busy[1]), 1);
    chk("rst_valid_a", 32'(r_valid[0]), 0);
    chk("rst_valid_b", 32'(r_valid[1]), 0);
    chk("rst_data_a", r_data[0], 0);
    chk("rst_data_b", r_data[1], 0);
    step();
    step();
    reset = 1'b0;

    sweep(c0, c1, 1'b1);
    chk("clear_len_a", c0, 16);
    chk("clear_len_b", c1, 12);

    for (int i = 0; i < 16; i++)
      op(0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(i), 32'h0);
    for (int i = 0; i < 12; i++)
      op(1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(i), 32'h0);
    repeat (3) step();

    for (int i = 0; i < 16; i++)
      op(0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].wm,
         tbl[i].re, tbl[i].ra, tbl[i].ex);

    op(0, 1'b1, 4'd3, 32'h1234_5678, 4'hF, 1'b0, 4'd0, 32'h0);
    op(0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3, 32'h1234_5678);
    op(0, 1'b1, 4'd3, 32'h0, 4'hF, 1'b0, 4'd0, 32'h0);
    chk("hold_data", r_data[0], 32'h1234_5678);
    chk("hold_valid", 32'(r_valid[0]), 0);
    step();
    chk("hold_data2", r_data[0], 32'h1234_5678);
    op(0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3, 32'h0);
    repeat (2) step();

    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (9) step();
    chk("mid_busy_a", 32'(init_busy[0]), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sweep(c0, c1, 1'b0);
    chk("restart_len_a", c0, 16);
    chk("restart_len_b", c1, 12);
    op(0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5,  32'h0);
    op(0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd11, 32'h0);
    op(0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd6,  32'h0);

    op(1, 1'b1, 4'd13, 32'hFFFF_FFFF, 4'hF, 1'b0, 4'd0, 32'h0);
    op(1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd13, 32'h0);
    for (int i = 0; i < 4; i++)
      op(1, 1'b1, 4'(i), 32'h0B0B_0000 | i, 4'hF,
         1'b0, 4'd0, 32'h0);
    for (int i = 0; i < 4; i++)
      op(1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(i),
         32'h0B0B_0000 | i);
    op(1, 1'b1, 4'd2, 32'hFFFF_FFFF, 4'h8,
       1'b1, 4'd2, 32'hFF0B_0002);
    op(1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd12, 32'h0);
    op(1, 1'b1, 4'd11, 32'h5A5A_5A5A, 4'hF, 1'b0, 4'd0, 32'h0);
    op(1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd11, 32'h5A5A_5A5A);
    repeat (4) step();

    chk("a_queue_empty", q0.size(), 0);
    chk("b_queue_empty", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
